// File: rtl/updn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updn_sweep_ctrl
// Purpose  : Drives an external up/down counter through a triangle sweep
//            Lo -> Hi -> Lo for a programmed number of passes. The counter
//            value is watched so direction reverses one step before each
//            bound, which means there is no dwell cycle at Hi or Lo.
// Ports    : clk_i, rst_i          clock, asynchronous active-high reset
//            start_i, abort_i      begin sweep (IDLE only) / synchronous stop
//            lo_bound_i, hi_bound_i, passes_i  programming, captured on Start
//            cnt_i                 counter value fed back
//            load_o, load_val_o, up_o, down_o  counter controls
//            busy_o, done_o, err_o, pass_cnt_o status
// Revision : 1.0  initial release
// ============================================================================
module updn_sweep_ctrl #(
  parameter int WIDTH  = 5,
  parameter int PASS_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIDTH-1:0]  lo_bound_i,
  input  logic [WIDTH-1:0]  hi_bound_i,
  input  logic [PASS_W-1:0] passes_i,
  input  logic [WIDTH-1:0]  cnt_i,
  output logic              load_o,
  output logic [WIDTH-1:0]  load_val_o,
  output logic              up_o,
  output logic              down_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [PASS_W-1:0] pass_cnt_o
);

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_UP   = 3'd2;
  localparam logic [2:0] C_DOWN = 3'd3;
  localparam logic [2:0] C_DONE = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [WIDTH-1:0]  lo_q,       lo_d;
  logic [WIDTH-1:0]  hi_q,       hi_d;
  logic [PASS_W-1:0] passes_q,   passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              err_q,      err_d;

  // Reversal thresholds; Lo < Hi is enforced at Start so neither wraps.
  logic [WIDTH-1:0]  hi_dec;
  logic [WIDTH-1:0]  lo_inc;
  logic [PASS_W-1:0] pass_inc;
  logic              bad_prog;

  assign hi_dec   = hi_q - WIDTH'(1);
  assign lo_inc   = lo_q + WIDTH'(1);
  assign pass_inc = pass_cnt_q + PASS_W'(1);
  assign bad_prog = (lo_bound_i >= hi_bound_i) || (passes_i == '0);

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      C_IDLE: begin
        // Abort dominates a simultaneous Start: nothing happens at all.
        if (start_i && !abort_i) begin
          if (bad_prog) begin
            err_d = 1'b1;
          end else begin
            lo_d       = lo_bound_i;
            hi_d       = hi_bound_i;
            passes_d   = passes_i;
            pass_cnt_d = '0;
            state_d    = C_LOAD;
          end
        end
      end
      C_LOAD: begin
        state_d = abort_i ? C_IDLE : C_UP;
      end
      C_UP: begin
        if (abort_i) begin
          state_d = C_IDLE;
        end else if (cnt_i == hi_dec) begin
          state_d = C_DOWN;
        end
      end
      C_DOWN: begin
        // An abort on the final step of a pass leaves Pass_Cnt untouched.
        if (abort_i) begin
          state_d = C_IDLE;
        end else if (cnt_i == lo_inc) begin
          pass_cnt_d = pass_inc;
          state_d    = (pass_inc == passes_q) ? C_DONE : C_UP;
        end
      end
      C_DONE: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= C_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
    end
  end

  assign load_o     = (state_q == C_LOAD);
  assign up_o       = (state_q == C_UP);
  assign down_o     = (state_q == C_DOWN);
  assign busy_o     = load_o | up_o | down_o;
  assign done_o     = (state_q == C_DONE);
  assign err_o      = err_q;
  assign load_val_o = lo_q;
  assign pass_cnt_o = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_updn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_updn_sweep_ctrl
// Purpose  : Self-checking bench for updn_sweep_ctrl with a behavioural
//            counter attached. Expected values come from the closed-form
//            triangle-wave arithmetic of the sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_updn_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] lo_b = '0;
  logic [4:0] hi_b = '0;
  logic [3:0] passes = '0;
  logic [4:0] cnt = 5'd0;
  logic       load, up, down, busy, done, err;
  logic [4:0] load_val;
  logic [3:0] pass_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int model_pc = 0;
  int model_lv = 0;

  always #5 clk = ~clk;

  updn_sweep_ctrl #(.WIDTH(5), .PASS_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .lo_bound_i(lo_b), .hi_bound_i(hi_b), .passes_i(passes), .cnt_i(cnt),
    .load_o(load), .load_val_o(load_val), .up_o(up), .down_o(down),
    .busy_o(busy), .done_o(done), .err_o(err), .pass_cnt_o(pass_cnt)
  );

  // The counter the controller drives: Load > Down > Up, no reset.
  always @(posedge clk) begin
    if (load)      cnt <= load_val;
    else if (down) cnt <= cnt - 5'd1;
    else if (up)   cnt <= cnt + 5'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int ld, input int u, input int dn,
                      input int bz, input int dnn, input int er, input int pc);
    chk({tag, ".load"},     {31'd0, load}, ld);
    chk({tag, ".up"},       {31'd0, up},   u);
    chk({tag, ".down"},     {31'd0, down}, dn);
    chk({tag, ".busy"},     {31'd0, busy}, bz);
    chk({tag, ".done"},     {31'd0, done}, dnn);
    chk({tag, ".err"},      {31'd0, err},  er);
    chk({tag, ".pass_cnt"}, {28'd0, pass_cnt}, pc);
    chk({tag, ".load_val"}, {27'd0, load_val}, model_lv);
  endtask

  // Counter value after edge E+k (k >= 1) of a sweep with span d.
  function automatic int exp_cnt(input int lo, input int d, input int k);
    int pos;
    pos = (k - 1) % (2 * d);
    return lo + ((pos <= d) ? pos : (2 * d - pos));
  endfunction

  // One sweep; abort_k / bstart_k / rst_k select an event at step k (-1 = none).
  task automatic run_sweep(input int lo, input int hi, input int p,
                           input int abort_k, input int bstart_k, input int rst_k);
    int d, last, pos, hold;
    d    = hi - lo;
    last = 1 + 2 * d * p;
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    lo_b = 5'(lo); hi_b = 5'(hi); passes = 4'(p);
    @(negedge clk);
    start = 1'b0;
    model_lv = lo;
    for (int k = 0; k <= last + 1; k++) begin
      if (k == 0) begin
        outs("load", 1, 0, 0, 1, 0, 0, 0);
      end else if (k < last) begin
        pos = (k - 1) % (2 * d);
        outs("sweep", 0, (pos < d) ? 1 : 0, (pos < d) ? 0 : 1, 1, 0, 0, (k - 1) / (2 * d));
        chk("sweep.cnt", {27'd0, cnt}, exp_cnt(lo, d, k));
      end else if (k == last) begin
        outs("done", 0, 0, 0, 0, 1, 0, p);
        chk("done.cnt", {27'd0, cnt}, lo);
      end else begin
        outs("idle", 0, 0, 0, 0, 0, 0, p);
        chk("idle.cnt", {27'd0, cnt}, lo);
        model_pc = p;
      end
      if (k == abort_k) begin
        model_pc = (k == 0) ? 0 : (k - 1) / (2 * d);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        hold = exp_cnt(lo, d, k + 1);
        for (int j = 0; j < 3; j++) begin
          outs("abort", 0, 0, 0, 0, 0, 0, model_pc);
          chk("abort.cnt", {27'd0, cnt}, hold);
          @(negedge clk);
        end
        return;
      end
      if (k == rst_k) begin
        hold = exp_cnt(lo, d, k);
        #2 rst = 1'b1;
        #1;
        model_pc = 0; model_lv = 0;
        outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst.cnt_hold", {27'd0, cnt}, hold);
        rst = 1'b0;
        @(negedge clk);
        outs("post_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst.cnt", {27'd0, cnt}, hold);
        return;
      end
      start = (k == bstart_k);
      if (k == bstart_k) begin
        lo_b = 5'd0; hi_b = 5'd31; passes = 4'd1;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Start with bad programming (or Start together with Abort).
  task automatic reject(input int lo, input int hi, input int p, input bit ab);
    @(negedge clk);
    start = 1'b1; abort = ab;
    lo_b = 5'(lo); hi_b = 5'(hi); passes = 4'(p);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    outs(ab ? "start_abort" : "reject", 0, 0, 0, 0, 0, ab ? 0 : 1, model_pc);
    @(negedge clk);
    outs(ab ? "start_abort2" : "reject2", 0, 0, 0, 0, 0, 0, model_pc);
  endtask

  initial begin
    int lo, hi, p, ak;
    #1;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    outs("reset_idle", 0, 0, 0, 0, 0, 0, 0);

    run_sweep(3, 6, 2, -1, -1, -1);
    run_sweep(3, 6, 2, -1, -1, 5);
    run_sweep(3, 6, 2, -1, 4, -1);
    reject(7, 7, 1, 1'b0);
    reject(2, 9, 0, 1'b0);
    reject(9, 4, 3, 1'b0);
    reject(3, 6, 2, 1'b1);
    run_sweep(30, 31, 3, -1, -1, -1);
    run_sweep(2, 8, 1, 10, -1, -1);
    run_sweep(0, 31, 1, -1, -1, -1);
    run_sweep(5, 9, 3, 0, -1, -1);

    for (int i = 0; i < 10; i++) begin
      lo = $urandom_range(0, 30);
      hi = $urandom_range(lo + 1, 31);
      p  = $urandom_range(1, 15);
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * (hi - lo) * p) : -1;
      run_sweep(lo, hi, p, ak, ($urandom_range(0, 1) == 0) ? 2 : -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
